// File: rtl/dmem_pkg.sv
// Shared types and defaults for the DataMemory arbiter: FSM states, owner encoding, bus widths.
package dmem_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic {
    OWNER_M0 = 1'b0,
    OWNER_M1 = 1'b1
  } owner_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and DataMemory.
// slave = arbiter view; master = requester/memory view.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_gnt;
  logic              m0_rvalid;

  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_gnt;
  logic              m1_rvalid;

  logic [DATA_W-1:0] rdata;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    input  mem_rdata,
    output m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, rdata,
    output mem_we, mem_addr, mem_wdata
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    output mem_rdata,
    input  m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, rdata,
    input  mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/dmem_arb_select.sv
// Combinational winner selection between m0 and m1.
// DMEM_ARB_ROUND_ROBIN_EN selects round-robin on ties; otherwise m0 has fixed priority.
module dmem_arb_select
  import dmem_pkg::*;
(
  input  logic   m0_req_i,
  input  logic   m1_req_i,
  input  owner_t last_owner_i,
  output owner_t winner_o,
  output logic   valid_o
);

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  always_comb begin
    valid_o = m0_req_i | m1_req_i;
    if (m0_req_i && m1_req_i) begin
      winner_o = (last_owner_i == OWNER_M0) ? OWNER_M1 : OWNER_M0;
    end else if (m0_req_i) begin
      winner_o = OWNER_M0;
    end else begin
      winner_o = OWNER_M1;
    end
  end
`else
  logic unused_last_owner;
  assign unused_last_owner = last_owner_i;

  always_comb begin
    valid_o  = m0_req_i | m1_req_i;
    winner_o = m0_req_i ? OWNER_M0 : OWNER_M1;
  end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of single-port DataMemory; all outputs registered.
// Tie policy set by DMEM_ARB_ROUND_ROBIN_EN (see dmem_arb_select).
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int READ_LAT = 1
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(READ_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(READ_LAT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  state_t             state_q, state_d;
  owner_t             last_owner_q, last_owner_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               m0_gnt_q, m0_gnt_d, m1_gnt_q, m1_gnt_d;
  logic               m0_rvalid_q, m0_rvalid_d, m1_rvalid_q, m1_rvalid_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;

  owner_t sel_winner;
  logic   sel_valid;

  dmem_arb_select u_select (
    .m0_req_i     (bus.m0_req),
    .m1_req_i     (bus.m1_req),
    .last_owner_i (last_owner_q),
    .winner_o     (sel_winner),
    .valid_o      (sel_valid)
  );

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    cnt_d        = cnt_q;
    m0_gnt_d     = 1'b0;
    m1_gnt_d     = 1'b0;
    m0_rvalid_d  = 1'b0;
    m1_rvalid_d  = 1'b0;
    rdata_d      = rdata_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;

    case (state_q)
      // RESP arbitrates exactly like IDLE so a waiting request costs no bubble.
      IDLE, RESP: begin
        if (sel_valid) begin
          state_d      = ISSUE;
          last_owner_d = sel_winner;
          if (sel_winner == OWNER_M1) begin
            m1_gnt_d    = 1'b1;
            mem_we_d    = bus.m1_we;
            mem_addr_d  = bus.m1_addr;
            mem_wdata_d = bus.m1_wdata;
          end else begin
            m0_gnt_d    = 1'b1;
            mem_we_d    = bus.m0_we;
            mem_addr_d  = bus.m0_addr;
            mem_wdata_d = bus.m0_wdata;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (mem_we_q) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT;
          cnt_d   = CNT_INIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_LAST;
        if (cnt_q == CNT_LAST) begin
          state_d     = RESP;
          rdata_d     = bus.mem_rdata;
          m0_rvalid_d = (last_owner_q == OWNER_M0);
          m1_rvalid_d = (last_owner_q == OWNER_M1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_owner_q <= OWNER_M1;
      cnt_q        <= '0;
      m0_gnt_q     <= 1'b0;
      m1_gnt_q     <= 1'b0;
      m0_rvalid_q  <= 1'b0;
      m1_rvalid_q  <= 1'b0;
      rdata_q      <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      cnt_q        <= cnt_d;
      m0_gnt_q     <= m0_gnt_d;
      m1_gnt_q     <= m1_gnt_d;
      m0_rvalid_q  <= m0_rvalid_d;
      m1_rvalid_q  <= m1_rvalid_d;
      rdata_q      <= rdata_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign bus.m0_gnt    = m0_gnt_q;
  assign bus.m1_gnt    = m1_gnt_q;
  assign bus.m0_rvalid = m0_rvalid_q;
  assign bus.m1_rvalid = m1_rvalid_q;
  assign bus.rdata     = rdata_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized traffic
// against a word-array reference model. Tie expectations follow DMEM_ARB_ROUND_ROBIN_EN.
module tb_dmem_arbiter #(
  parameter int READ_LAT = 1
);

  logic clk;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LAT(READ_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // DataMemory stand-in: synchronous write, READ_LAT-deep registered read.
  logic [31:0] env_mem [0:63];
  logic [31:0] rpipe [READ_LAT];
  always @(posedge clk) begin
    if (bus.mem_we) env_mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
    rpipe[0] <= env_mem[bus.mem_addr[7:2]];
    for (int i = 1; i < READ_LAT; i++) rpipe[i] <= rpipe[i-1];
  end
  assign bus.mem_rdata = rpipe[READ_LAT-1];

  // Reference model: last value written to each word.
  logic [31:0] ref_mem [0:15];

  int n_rv0 = 0;
  int n_rv1 = 0;
  logic [31:0] we_addr_q[$];
  logic [31:0] we_data_q[$];
  always @(negedge clk) begin
    if (bus.m0_rvalid) n_rv0 <= n_rv0 + 1;
    if (bus.m1_rvalid) n_rv1 <= n_rv1 + 1;
    if (bus.mem_we) begin
      we_addr_q.push_back(bus.mem_addr);
      we_data_q.push_back(bus.mem_wdata);
    end
  end

  task automatic do_access(input int port, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, output int g_cyc, output int r_cyc,
                           output logic [31:0] rd, output logic [31:0] g_addr,
                           output logic g_we, output bit timeout);
    g_cyc = -1; r_cyc = -1; rd = '0; g_addr = '0; g_we = 1'b0; timeout = 1'b0;
    if (port == 0) begin
      bus.m0_req = 1'b1; bus.m0_we = we; bus.m0_addr = addr; bus.m0_wdata = wdata;
    end else begin
      bus.m1_req = 1'b1; bus.m1_we = we; bus.m1_addr = addr; bus.m1_wdata = wdata;
    end
    for (int i = 0; i < 40 && g_cyc < 0; i++) begin
      @(negedge clk);
      if ((port == 0 && bus.m0_gnt) || (port == 1 && bus.m1_gnt)) begin
        g_cyc = cyc; g_addr = bus.mem_addr; g_we = bus.mem_we;
      end
    end
    if (port == 0) bus.m0_req = 1'b0; else bus.m1_req = 1'b0;
    if (g_cyc < 0) timeout = 1'b1;
    else if (!we) begin
      for (int i = 0; i < READ_LAT + 10 && r_cyc < 0; i++) begin
        @(negedge clk);
        if ((port == 0 && bus.m0_rvalid) || (port == 1 && bus.m1_rvalid)) begin
          r_cyc = cyc; rd = bus.rdata;
        end
      end
      if (r_cyc < 0) timeout = 1'b1;
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    bus.m0_req = 1'b0; bus.m1_req = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [135:0] outs;
    apply_reset();
    outs = {bus.m0_gnt, bus.m1_gnt, bus.m0_rvalid, bus.m1_rvalid, bus.rdata,
            bus.mem_we, bus.mem_addr, bus.mem_wdata, 36'd0};
    checks++;
    if (outs !== '0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 0", outs);
    end
    @(negedge clk);
    checks++;
    if ({bus.m0_gnt, bus.m1_gnt, bus.mem_we} !== 3'b000) begin
      errors++; $display("FAIL reset_idle: gnt/we %b expected 000", {bus.m0_gnt, bus.m1_gnt, bus.mem_we});
    end
    $display("reset: outputs checked");
  endtask

  task automatic test_preload();
    int g, r; logic [31:0] rd, ga, v; logic gw; bit to;
    for (int i = 0; i < 16; i++) begin
      v = (i < 6) ? 32'(10 * (i + 1)) : $urandom;
      do_access(1, 1'b1, 32'(4 * i), v, g, r, rd, ga, gw, to);
      ref_mem[i] = v;
      checks++;
      if (to) begin errors++; $display("FAIL preload_timeout: word %0d got no gnt", i); end
      $display("preload: m1 write addr=%0d data=%0d gnt@%0d", 4 * i, v, g);
    end
  endtask

  task automatic test_seq_read_m1();
    int g, r; logic [31:0] rd, ga; logic gw; bit to; int rv0_before;
    rv0_before = n_rv0;
    for (int i = 0; i < 6; i++) begin
      do_access(1, 1'b0, 32'(4 * i), 32'd0, g, r, rd, ga, gw, to);
      checks++;
      if (to || rd !== ref_mem[i]) begin
        errors++; $display("FAIL seq_read_data: addr %0d got %0d expected %0d (timeout=%0d)", 4 * i, rd, ref_mem[i], to);
      end
      checks++;
      if (r - g !== READ_LAT + 1) begin
        errors++; $display("FAIL seq_read_latency: got %0d expected %0d", r - g, READ_LAT + 1);
      end
      $display("seq_read: m1 addr=%0d rdata=%0d gnt@%0d rvalid@%0d", 4 * i, rd, g, r);
    end
    @(negedge clk);
    checks++;
    if (n_rv0 !== rv0_before) begin
      errors++; $display("FAIL seq_read_no_m0_rvalid: got %0d pulses expected 0", n_rv0 - rv0_before);
    end
  endtask

  task automatic test_write_read();
    int g, r; logic [31:0] rd, ga; logic gw; bit to;
    we_addr_q.delete(); we_data_q.delete();
    do_access(0, 1'b1, 32'd24, 32'd1234, g, r, rd, ga, gw, to);
    ref_mem[6] = 32'd1234;
    repeat (3) @(negedge clk);
    checks++;
    if (to || we_addr_q.size() !== 1) begin
      errors++; $display("FAIL write_we_pulses: got %0d cycles expected 1", we_addr_q.size());
    end else begin
      checks++;
      if (we_addr_q[0] !== 32'd24 || we_data_q[0] !== 32'd1234) begin
        errors++; $display("FAIL write_bus: got addr %0d data %0d expected 24/1234", we_addr_q[0], we_data_q[0]);
      end
    end
    $display("write_read: m0 write addr=24 data=1234 gnt@%0d", g);
    do_access(0, 1'b0, 32'd24, 32'd0, g, r, rd, ga, gw, to);
    checks++;
    if (to || rd !== ref_mem[6]) begin
      errors++; $display("FAIL write_read_data: got %0d expected %0d", rd, ref_mem[6]);
    end
    $display("write_read: m0 read addr=24 rdata=%0d", rd);
  endtask

  task automatic test_tie();
    int g0, g1, r0, r1, n0, n1; logic [31:0] d0, d1; bit exp_m1;
    apply_reset();
    g0 = -1; g1 = -1; r0 = -1; r1 = -1; d0 = '0; d1 = '0;
    bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 32'd0;
    bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 32'd4;
    for (int i = 0; i < 40 && (r0 < 0 || r1 < 0); i++) begin
      @(negedge clk);
      if (bus.m0_gnt && g0 < 0) begin g0 = cyc; bus.m0_req = 1'b0; end
      if (bus.m1_gnt && g1 < 0) begin g1 = cyc; bus.m1_req = 1'b0; end
      if (bus.m0_rvalid) begin r0 = cyc; d0 = bus.rdata; end
      if (bus.m1_rvalid) begin r1 = cyc; d1 = bus.rdata; end
    end
    bus.m0_req = 1'b0; bus.m1_req = 1'b0;
    checks++;
    if (g0 < 0 || g1 - g0 !== READ_LAT + 2) begin
      errors++; $display("FAIL tie_grant_order: m0 gnt@%0d m1 gnt@%0d expected m1 %0d later", g0, g1, READ_LAT + 2);
    end
    checks++;
    if (r0 < 0 || r1 - r0 !== READ_LAT + 2) begin
      errors++; $display("FAIL tie_rvalid_gap: got %0d expected %0d", r1 - r0, READ_LAT + 2);
    end
    checks++;
    if (d0 !== ref_mem[0] || d1 !== ref_mem[1]) begin
      errors++; $display("FAIL tie_data: got %0d/%0d expected %0d/%0d", d0, d1, ref_mem[0], ref_mem[1]);
    end
    $display("tie: m0 gnt@%0d rv@%0d d=%0d, m1 gnt@%0d rv@%0d d=%0d", g0, r0, d0, g1, r1, d1);

    n0 = 0; n1 = 0;
    bus.m0_req = 1'b1; bus.m1_req = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.m0_gnt) n0++;
      if (bus.m1_gnt) n1++;
    end
    bus.m0_req = 1'b0; bus.m1_req = 1'b0;
    repeat (READ_LAT + 6) @(negedge clk);
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    exp_m1 = 1'b1;
`else
    exp_m1 = 1'b0;
`endif
    checks++;
    if ((n1 > 0) !== exp_m1 || n0 == 0) begin
      errors++; $display("FAIL tie_held: m0 gnts %0d m1 gnts %0d expected m1 served=%0d", n0, n1, exp_m1);
    end
    $display("tie_held: m0 gnts=%0d m1 gnts=%0d", n0, n1);
  endtask

  task automatic test_back_to_back();
    int g[3]; int r; logic [31:0] rd, ga; logic gw; bit to;
    for (int i = 0; i < 3; i++) begin
      do_access(1, 1'b1, 32'(28 + 4 * i), 32'(7 + i), g[i], r, rd, ga, gw, to);
      ref_mem[7 + i] = 32'(7 + i);
      $display("back_to_back: m1 write addr=%0d data=%0d gnt@%0d", 28 + 4 * i, 7 + i, g[i]);
    end
    checks++;
    if (g[1] - g[0] !== 2 || g[2] - g[1] !== 2) begin
      errors++; $display("FAIL b2b_gnt_spacing: got %0d,%0d expected 2,2", g[1] - g[0], g[2] - g[1]);
    end
    for (int i = 0; i < 3; i++) begin
      do_access(1, 1'b0, 32'(28 + 4 * i), 32'd0, g[0], r, rd, ga, gw, to);
      checks++;
      if (to || rd !== ref_mem[7 + i]) begin
        errors++; $display("FAIL b2b_readback: addr %0d got %0d expected %0d", 28 + 4 * i, rd, ref_mem[7 + i]);
      end
      $display("back_to_back: read addr=%0d rdata=%0d", 28 + 4 * i, rd);
    end
  endtask

  task automatic test_reset_mid();
    int g, r, rv0_before; logic [31:0] rd, ga; logic gw; bit to;
    logic [135:0] outs;
    g = -1;
    rv0_before = n_rv0;
    bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 32'd8;
    for (int i = 0; i < 40 && g < 0; i++) begin
      @(negedge clk);
      if (bus.m0_gnt) g = cyc;
    end
    bus.m0_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    outs = {bus.m0_gnt, bus.m1_gnt, bus.m0_rvalid, bus.m1_rvalid, bus.rdata,
            bus.mem_we, bus.mem_addr, bus.mem_wdata, 36'd0};
    checks++;
    if (g < 0 || outs !== '0) begin
      errors++; $display("FAIL reset_mid_outputs: got %h expected 0 (gnt@%0d)", outs, g);
    end
    repeat (READ_LAT + 4) @(negedge clk);
    checks++;
    if (n_rv0 !== rv0_before) begin
      errors++; $display("FAIL reset_mid_dropped: got %0d m0 rvalids expected 0", n_rv0 - rv0_before);
    end
    $display("reset_mid: read addr=8 aborted at gnt@%0d", g);
    do_access(0, 1'b0, 32'd8, 32'd0, g, r, rd, ga, gw, to);
    checks++;
    if (to || rd !== ref_mem[2]) begin
      errors++; $display("FAIL reset_mid_retry: got %0d expected %0d", rd, ref_mem[2]);
    end
    $display("reset_mid: retry read addr=8 rdata=%0d", rd);
  endtask

  task automatic test_latency();
    int g, r; logic [31:0] rd, ga; logic gw; bit to;
    do_access(0, 1'b0, 32'd12, 32'd0, g, r, rd, ga, gw, to);
    checks++;
    if (to || r - g !== READ_LAT + 1) begin
      errors++; $display("FAIL latency: got %0d expected %0d", r - g, READ_LAT + 1);
    end
    checks++;
    if (rd !== ref_mem[3]) begin
      errors++; $display("FAIL latency_data: got %0d expected %0d", rd, ref_mem[3]);
    end
    $display("latency: m0 read addr=12 rdata=%0d gnt@%0d rvalid@%0d", rd, g, r);
  endtask

  task automatic test_random();
    int g, r, port, w; logic [31:0] rd, ga, addr, data; logic gw, we; bit to;
    for (int n = 0; n < 40; n++) begin
      port = $urandom_range(0, 1);
      we   = 1'($urandom_range(0, 1));
      w    = $urandom_range(0, 15);
      addr = 32'(w * 4 + $urandom_range(0, 3));
      data = $urandom;
      do_access(port, we, addr, data, g, r, rd, ga, gw, to);
      checks++;
      if (to || ga !== addr || gw !== we) begin
        errors++; $display("FAIL rand_issue: addr %h we %0d expected %h/%0d (timeout=%0d)", ga, gw, addr, we, to);
      end
      if (we) ref_mem[w] = data;
      else begin
        checks++;
        if (rd !== ref_mem[w] || r - g !== READ_LAT + 1) begin
          errors++; $display("FAIL rand_read: addr %h got %h lat %0d expected %h lat %0d", addr, rd, r - g, ref_mem[w], READ_LAT + 1);
        end
      end
      $display("random: m%0d %s addr=%h data=%h gnt@%0d", port, we ? "wr" : "rd", addr, we ? data : rd, g);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.m0_req = 1'b0; bus.m0_we = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0;
    bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0;
    @(negedge clk);
    test_reset();
    test_preload();
    test_seq_read_m1();
    test_write_read();
    test_tie();
    test_back_to_back();
    test_reset_mid();
    test_latency();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter/sequencer in front of the single-port DataMemory (32-bit byte address, word data, synchronous read).
- Port m0 is the CPU load/store path. Port m1 is a debug/loader path used to preload or dump memory.
- Grants one access at a time, drives DataMemory's memWrite/address/writeData, and returns readData to the owning requester with a valid pulse.

Parameters:
- ADDR_W, 32, address width (byte address, passed through unchanged)
- DATA_W, 32, data width
- READ_LAT, 1, DataMemory read latency in cycles from address presented (≥1)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- m0_req  in  1  CPU access request; hold with m0_we/m0_addr/m0_wdata until m0_gnt seen
- m0_we  in  1  1=write, 0=read
- m0_addr  in  ADDR_W  byte address
- m0_wdata  in  DATA_W  write data
- m0_gnt  out  1  one-cycle pulse: request accepted
- m0_rvalid  out  1  one-cycle pulse: rdata holds m0 read result
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid  same as m0, for the loader port
- rdata  out  DATA_W  read result, shared by both ports, qualified by mN_rvalid
- mem_we  out  1  to DataMemory memWrite
- mem_addr  out  ADDR_W  to DataMemory address
- mem_wdata  out  DATA_W  to DataMemory writeData
- mem_rdata  in  DATA_W  from DataMemory readData

Behaviour:
- All outputs are registered. Reset values: mN_gnt=0, mN_rvalid=0, rdata=0, mem_we=0, mem_addr=0, mem_wdata=0, FSM=IDLE, last_owner=1 (so m0 wins the first tie), wait counter=0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: at each posedge, if any req is high, select a winner, register its addr/wdata/we into mem_*, pulse its gnt, record the owner, and go to ISSUE. With no req, stay in IDLE.
- ISSUE, cycle N: gnt high for the owner only. mem_we=owner we.
  - Write: go to IDLE; mem_we returns to 0 on the next cycle. Writes occupy 2 cycles.
  - Read: go to WAIT with counter=READ_LAT.
- WAIT: mem_we=0; mem_addr held. Decrement the counter each cycle. On the cycle the counter is 1, capture mem_rdata into rdata at the posedge and go to RESP.
- RESP, cycle N+READ_LAT+1: owner rvalid=1; rdata is valid.
  - RESP arbitrates exactly like IDLE (no bubble). If a req is present, go to ISSUE; otherwise go to IDLE.
- rdata holds its value until the next read capture.
- Requests are not sampled in ISSUE or WAIT. A requester drops or changes req on the posedge after it sees gnt. Arbitration then sees the updated req.
- A write followed by a read of the same address returns the new data, because the write completes in its ISSUE cycle.
- Address bits [1:0] are passed through unmodified; word indexing is done by DataMemory.
- Reset mid-operation: a sync rst has priority over all transitions. An in-flight read is dropped with no rvalid. A write whose ISSUE cycle coincides with rst still commits, since mem_we was already registered; a write is never generated after rst.
- The wait counter width is $clog2(READ_LAT+1).

Optional Feature:
- Macro: DMEM_ARB_ROUND_ROBIN_EN.
- Defined: round-robin. When both req are high, the port that is not last_owner wins. last_owner updates on every grant.
- Undefined: fixed priority; m0 always wins ties, and m1 is served only when m0_req=0. last_owner is still tracked but not used for selection.

Decomposition:
- Shared package dmem_pkg:
  - state enum (IDLE/ISSUE/WAIT/RESP)
  - owner encoding (OWNER_M0=0, OWNER_M1=1)
  - default ADDR_W/DATA_W constants
- One natural sub-module: dmem_arb_select. It is combinational and, given m0_req, m1_req and last_owner, produces the winner and a valid flag. The feature macro selects its policy.

Test Plan:
- Sequential reads on m1 from addresses 0,4,8,12,16,20 (preloaded 10,20,30,40,50,60):
  - m1_gnt in cycle N, m1_rvalid in N+2 (READ_LAT=1)
  - rdata = 10..60 in order
  - m0_rvalid never asserted
- m0 writes 1234 to address 24, then m0 reads address 24:
  - mem_we high exactly one cycle with mem_addr=24, mem_wdata=1234
  - read returns rdata=1234
- m0 and m1 both request reads (addr 0 and 4) in the same cycle with DMEM_ARB_ROUND_ROBIN_EN defined, right after reset: m0 granted first, m1 granted in m0's RESP cycle, rvalids come 3 cycles apart. Same stimulus without the macro, with m0_req held continuously: m1 is never granted.
- Back-to-back writes on m1 to addresses 28,32,36 (values 7,8,9): the gnts are 2 cycles apart; a later read-back returns 7,8,9.
- Assert rst during WAIT of an m0 read to address 8: no m0_rvalid is produced and all outputs are 0 the next cycle. A following m0 read to address 8 then completes normally with rdata=30.
- READ_LAT=3 build with a read of address 12: m0_rvalid comes exactly 4 cycles after m0_gnt, and rdata=40.
